md_unit: RTL and testbench
==========================

# md_unit

Iterative RV32M multiply/divide unit for the single-cycle CPU. It sits between the register bank and the write-back mux. It consumes the register bank's `rs1_out`/`rs2_out`, and its `md_result` feeds the `wb_out` mux. While an M-extension instruction is in flight, it asserts `stall` so the core holds PC. The write then lands through the register bank's negedge write in the final (done) cycle.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  decoded "current instruction is OP with funct7=0000001"; level, combinational from decode.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_out`  in  32  operand A (dividend / multiplicand).
- `rs2_out`  in  32  operand B (divisor / multiplier).
- `stall`  out  1  hold PC and suppress RegWen this cycle.
- `busy`  out  1  high in CALC.
- `done`  out  1  high for exactly one cycle while `md_result` is final.
- `md_result`  out  32  result; held until the next accepted `start`.

## Operation
- States: IDLE, CALC, DONE.
- Reset values: state=IDLE, `md_result`=0, `done`=0, `busy`=0. `stall` resets to 0 (it is combinational, and `start` is 0 under reset).
- IDLE, `start`=1 at a rising edge: the operation is accepted.
  - Latch `funct3`, operand magnitudes and result-sign flag.
  - Load counter with 31.
  - Go to CALC, except for special cases, which go straight to DONE.
- Special cases, resolved at acceptance with `md_result` loaded the same edge:
  - DIV/DIVU with B=0: quotient 0xFFFFFFFF.
  - REM/REMU with B=0: result = A.
  - DIV with A=0x80000000, B=0xFFFFFFFF: result 0x80000000.
  - REM with A=0x80000000, B=0xFFFFFFFF: result 0.
- CALC: one iteration per edge; counter decrements; at the edge where counter==0, go to DONE and load `md_result`.
  - Multiply: shift-add over the 64-bit product.
  - Divide: restoring, one quotient bit per edge.
- Signedness:
  - Signed operands (MULH both; MULHSU A only; DIV/REM both) are converted to magnitude.
  - Product is negated (64-bit two's complement) when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
- DONE: `done`=1; always go to IDLE on the next edge. `start` is ignored in DONE, because the same instruction is still presented.
- `start` in CALC is ignored. `funct3` and operand changes after acceptance have no effect.
- `stall` = (IDLE & `start`) | CALC. It is 0 in DONE, so PC advances at the edge leaving DONE.
- Asynchronous reset mid-CALC or mid-DONE: immediate IDLE, `md_result`=0, `done`=0. Partial results are discarded.

## Timing
- Edge T0 accepts. CALC covers edges T1..T32, giving 32 iterations. DONE runs from T32 to T33, with `done`=1 and `md_result` valid. IDLE resumes at T33.
- Normal latency: `stall` high from the cycle `start` rises through T32, which is 33 cycles. Total occupancy is 34 cycles including DONE.
- Special-case latency: DONE runs T0..T1; `stall` high for 1 cycle only.
- A back-to-back M-op presented at T33 is accepted at T34.
- `md_result` is registered and stable through the whole DONE cycle, including the negedge write.

## Test plan
- MUL A=7, B=0xFFFFFFFD (−3):
  - `md_result`=0xFFFFFFEB.
  - `done` is a single pulse after T32.
  - `stall` high for exactly 33 cycles.
- MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU A=0x12345678, B=0 → 0xFFFFFFFF in 1 cycle. REMU with the same operands → 0x12345678. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0. All special cases: `done` at T0..T1, no CALC.
- Hold `start`=1 through DONE → no second operation. Change operands during CALC → result unchanged. Present a new M-op right after DONE → accepted one edge later.
- Deassert `rst_n` at iteration 10 → `busy`, `stall` and `done` go to 0 and `md_result`=0 immediately. After release, a fresh MUL 3×5 → 15.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit, one iteration per cycle over 32 cycles.
module md_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_out,
    input  logic [31:0] rs2_out,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] md_result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [2:0]  op;
    logic [4:0]  cnt;
    logic        neg;
    logic [31:0] m, hi, lo;
    logic        a_sgn, b_sgn, a_neg, b_neg, is_div, is_rem, div0, ovf, special, acc_neg;
    logic [31:0] a_mag, b_mag, spec_res;
    logic [32:0] mul_sum, div_r, div_d;
    logic        div_ge;
    logic [31:0] hi_nx, lo_nx, div_val, div_res, fin;
    logic [63:0] prod;

    assign a_sgn    = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    assign b_sgn    = funct3 inside {3'b001, 3'b100, 3'b110};
    assign a_neg    = a_sgn & rs1_out[31];
    assign b_neg    = b_sgn & rs2_out[31];
    assign a_mag    = a_neg ? -rs1_out : rs1_out;
    assign b_mag    = b_neg ? -rs2_out : rs2_out;
    assign is_div   = funct3[2];
    assign is_rem   = funct3[2] & funct3[1];
    assign div0     = is_div & (rs2_out == 32'd0);
    assign ovf      = is_div & ~funct3[0] & (rs1_out == 32'h8000_0000) & (rs2_out == 32'hFFFF_FFFF);
    assign special  = div0 | ovf;
    assign spec_res = div0 ? (is_rem ? rs1_out : 32'hFFFF_FFFF) : (is_rem ? 32'd0 : 32'h8000_0000);
    // remainder follows the dividend; quotient and product follow the sign difference
    assign acc_neg  = is_rem ? a_neg : a_neg ^ b_neg;

    // multiply: hi:lo holds partial product with multiplier bits shifting out of lo
    // divide: hi is the partial remainder, lo shifts dividend out and quotient in
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
    assign div_r   = {hi, lo[31]};
    assign div_d   = div_r - {1'b0, m};
    assign div_ge  = ~div_d[32];
    assign hi_nx   = op[2] ? (div_ge ? div_d[31:0] : div_r[31:0]) : mul_sum[32:1];
    assign lo_nx   = op[2] ? {lo[30:0], div_ge} : {mul_sum[0], lo[31:1]};
    assign prod    = neg ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    assign div_val = op[1] ? hi_nx : lo_nx;
    assign div_res = neg ? -div_val : div_val;
    assign fin     = op[2] ? div_res : (op == 3'b000 ? prod[31:0] : prod[63:32]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        if (state == IDLE) state_nx = start ? (special ? DONE : CALC) : IDLE;
        if (state == CALC) state_nx = (cnt == 5'd0) ? DONE : CALC;
    end

    always_comb begin
        busy  = state == CALC;
        done  = state == DONE;
        stall = (state == IDLE && start) || state == CALC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= 3'd0;
            cnt       <= 5'd0;
            neg       <= 1'b0;
            m         <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            md_result <= 32'd0;
        end else if (state == IDLE && start) begin
            op  <= funct3;
            neg <= acc_neg;
            cnt <= 5'd31;
            hi  <= 32'd0;
            m   <= is_div ? b_mag : a_mag;
            lo  <= is_div ? a_mag : b_mag;
            if (special) md_result <= spec_res;
        end else if (state == CALC) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) md_result <= fin;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit results, latency, special cases and reset.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [2:0]  funct3;
    logic [31:0] rs1_out, rs2_out;
    logic        stall, busy, done;
    logic [31:0] md_result;
    int          checks = 0;
    int          errors = 0;

    md_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_out(rs1_out), .rs2_out(rs2_out),
        .stall(stall), .busy(busy), .done(done), .md_result(md_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // call just after a negedge with start already driven; returns at the negedge+1 where done is seen
    task automatic wait_done(input string tag, output int n);
        bit seen;
        n = 0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (done) begin
                seen = 1;
                break;
            end
            if (stall) n++;
            @(negedge clk);
        end
        chk({tag, "_done"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_stall);
        int n;
        @(negedge clk);
        start = 1; funct3 = f; rs1_out = a; rs2_out = b;
        wait_done(tag, n);
        chk({tag, "_res"}, md_result, exp);
        chk({tag, "_stall_cycles"}, n, exp_stall);
        chk({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
        start = 0;
        @(negedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_res_hold"}, md_result, exp);
    endtask

    initial begin
        int n;
        rst_n = 0; start = 0; funct3 = 0; rs1_out = 0; rs2_out = 0;
        #1;
        chk("rst_res", md_result, 32'd0);
        chk("rst_flags", {29'd0, stall, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        run("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        run("divu0", 3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        run("remu0", 3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // DIV, then REM presented during DONE with start held: ignored in DONE, accepted one edge later
        @(negedge clk);
        start = 1; funct3 = 3'b100; rs1_out = 32'hFFFF_FFF9; rs2_out = 32'd2;
        wait_done("div", n);
        chk("div_res", md_result, 32'hFFFF_FFFD);
        funct3 = 3'b110;
        @(negedge clk);
        #1;
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
        chk("b2b_idle_done", {31'd0, done}, 32'd0);
        chk("b2b_idle_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("b2b_accepted", {31'd0, busy}, 32'd1);
        @(negedge clk);
        wait_done("rem", n);
        chk("rem_res", md_result, 32'hFFFF_FFFF);
        start = 0;

        // operand and funct3 changes mid-CALC must not disturb the result
        @(negedge clk);
        start = 1; funct3 = 3'b101; rs1_out = 32'd100; rs2_out = 32'd7;
        repeat (5) @(negedge clk);
        funct3 = 3'b000; rs1_out = 32'hDEAD_BEEF; rs2_out = 32'd3;
        wait_done("chg", n);
        chk("chg_res", md_result, 32'd14);
        start = 0;

        // reset mid-CALC at iteration 10
        @(negedge clk);
        start = 1; funct3 = 3'b000; rs1_out = 32'd9; rs2_out = 32'd9;
        repeat (11) @(negedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 0; start = 0;
        #1;
        chk("mid_rst_flags", {29'd0, stall, busy, done}, 32'd0);
        chk("mid_rst_res", md_result, 32'd0);
        @(negedge clk);
        rst_n = 1;
        run("mul_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
